id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID->EX pipeline register of the 5-stage core, with load-use hazard detection.
//  - Captures decoded control signals, operands and immediates from ID.
//  - Inserts a bubble and stalls IF/ID when the EX-stage load feeds the ID instruction.
//  - Clears its contents on a taken branch or jump resolved in EX.
// PARAMETERS
//  XLEN             32    datapath width
//  LOAD_RESULT_SEL  2'd1  result_sel encoding that marks a load
// PORTS
//  clk                   in   1     core clock
//  rst                   in   1     synchronous active-high reset
//  valid_ID              in   1     ID holds a real instruction
//  reg_write_ID          in   1     control from decode
//  mem_write_ID          in   1     control from decode
//  uncond_jump_ID        in   1     control from decode
//  meet_branch_ID        in   1     control from decode
//  pc_jal_sel_ID         in   1     control from decode
//  result_sel_ID         in   2     control from decode
//  alu_sel_rs1_ID        in   2     control from decode
//  alu_sel_rs2_ID        in   2     control from decode
//  alu_ctrl_ID           in   4     control from decode
//  rd1_ID, rd2_ID        in   XLEN  register-file read data
//  pc_ID, pc_plus4_ID    in   XLEN  instruction PC and PC+4
//  imm_ext_ID            in   XLEN  sign-extended immediate
//  rs1_ID, rs2_ID, rd_ID in   5     register indices
//  funct3_ID             in   3     branch/load/store width select
//  flush_EX              in   1     taken branch/jump resolved in EX this cycle
//  stall_ext             in   1     downstream (MEM) wait: hold all EX state
//  *_EX (all of above)   out  same  registered copies; valid_EX replaces valid_ID
//  stall_IF, stall_ID    out  1     hold PC and IF/ID register (combinational)
//  bubble_cnt, flush_cnt out  32    perf counters, see CONFIGURATION
// BEHAVIOUR
//  - Reset: all *_EX outputs and counters are 0. valid_EX=0, giving a bubble.
//  - Load-use detect (combinational): lu = valid_EX & (result_sel_EX==LOAD_RESULT_SEL)
//    & (rd_EX!=0) & valid_ID & ((rd_EX==rs1_ID)|(rd_EX==rs2_ID)).
//    - rs usage is not qualified by opcode, so the check is conservative; a spurious stall is legal.
//  - stall_IF = stall_ID = (lu & ~flush_EX) | stall_ext.
//  - Per-edge priority (latency 1 cycle, ID->EX):
//    1. rst: clear all state.
//    2. flush_EX: load a bubble. flush overrides stall_ext.
//    3. stall_ext: hold every *_EX register.
//    4. lu: load a bubble. ID holds, so the same instruction re-evaluates next cycle, exactly 1 bubble per load.
//    5. else: load all *_ID fields, with valid_EX = valid_ID.
//  - Bubble: valid_EX, reg_write_EX, mem_write_EX, uncond_jump_EX and meet_branch_EX are 0.
//    Remaining control and data fields are loaded from ID and are don't-care; the bench must not check them.
//  - flush_EX and lu cannot be true together: EX cannot be both a load and a taken branch.
//    If they coincide, flush wins and the stall outputs are 0.
//  - rst asserted mid-stall: the next cycle shows valid_EX=0 and the stall outputs are 0.
// CONFIGURATION
//  - PERF_CNT_EN defined:
//    - bubble_cnt increments on each edge that loads a bubble because of lu.
//    - flush_cnt increments on each edge where flush_EX=1.
//    - Both counters are 32-bit, wrap at 2^32, clear on rst, and do not count during rst.
//  - PERF_CNT_EN undefined: bubble_cnt and flush_cnt are tied to 0 and no counter flops exist.
// STRUCTURE
//  - Shared riscv_defs.vh holds the result_sel, alu_ctrl and alu_sel encodings and LOAD_RESULT_SEL.
//  - One sub-module: load_use_detect (pure combinational lu equation).
//  - The register bank and counters stay in id_ex_stage.
// TESTING
//  1. Reset held 3 cycles with ID inputs non-zero -> all *_EX=0, stall_*=0, counters=0.
//  2. Load x5 in EX, ID add reads rs1=5 -> stall_IF/ID=1 for 1 cycle, next cycle valid_EX=0
//     and reg_write_EX=0; the following cycle the add is in EX; bubble_cnt=1.
//  3. Load with rd_EX=0, ID reads rs2=0 -> no stall, add passes straight through.
//  4. flush_EX=1 with ID holding a store -> next cycle valid_EX=0 and mem_write_EX=0;
//     flush_cnt=1, stall outputs 0.
//  5. stall_ext=1 for 2 cycles with varying ID inputs -> *_EX unchanged;
//     stall_ext and flush_EX together -> bubble loaded.
//  6. PERF_CNT_EN built, bubble_cnt preloaded via force to 32'hFFFF_FFFF,
//     one load-use -> bubble_cnt=0; build without macro -> counters constantly 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared decode encodings and the ID->EX control bundle for the 5-stage core.
// Latency: n/a (types, constants and helper only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    // result_sel: which value the writeback mux returns.
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_IMM  = 2'd3
    } result_sel_e;

    // alu_sel_rs1 / alu_sel_rs2: ALU operand source.
    typedef enum logic [1:0] {
        ALU_SRC_REG  = 2'd0,
        ALU_SRC_PC   = 2'd1,
        ALU_SRC_IMM  = 2'd2,
        ALU_SRC_ZERO = 2'd3
    } alu_sel_e;

    // alu_ctrl: ALU operation.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    // result_sel value that marks an instruction as a load.
    localparam logic [1:0] LOAD_RESULT_SEL_DEF = RES_LOAD;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_write;
        logic       uncond_jump;
        logic       meet_branch;
        logic       pc_jal_sel;
        logic [1:0] result_sel;
        logic [1:0] alu_sel_rs1;
        logic [1:0] alu_sel_rs2;
        logic [3:0] alu_ctrl;
    } ctrl_t;

    // A bubble only needs the architecturally visible side effects killed;
    // the other fields are don't-care downstream and pass through unchanged.
    function automatic ctrl_t make_bubble(input ctrl_t c);
        ctrl_t b;
        b             = c;
        b.valid       = 1'b0;
        b.reg_write   = 1'b0;
        b.mem_write   = 1'b0;
        b.uncond_jump = 1'b0;
        b.meet_branch = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: EX holds a load whose rd is read by the ID instruction.
// Latency: combinational.
// Backpressure: none; the result drives the stall/bubble decision in id_ex_stage.
// Ports: valid_ex_i/result_sel_ex_i/rd_ex_i (EX instruction), valid_id_i/rs1_id_i/rs2_id_i
//        (ID instruction), lu_o (hazard present).
module id_ex_stage_load_use_detect #(
    parameter logic [1:0] LOAD_RESULT_SEL = 2'd1
) (
    input  logic       valid_ex_i,
    input  logic [1:0] result_sel_ex_i,
    input  logic [4:0] rd_ex_i,
    input  logic       valid_id_i,
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    output logic       lu_o
);

    logic ex_is_load;
    logic rs_match;

    assign ex_is_load = valid_ex_i && (result_sel_ex_i == LOAD_RESULT_SEL) && (rd_ex_i != 5'd0);
    // rs fields are compared whether or not the opcode reads them; an occasional
    // unnecessary stall is harmless, a missed one is not.
    assign rs_match   = (rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i);
    assign lu_o       = ex_is_load && valid_id_i && rs_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion and EX-flush.
// Latency: 1 cycle ID->EX; stall_IF/stall_ID are combinational.
// Backpressure: stall_ext holds all EX state; flush_EX overrides it; load-use holds IF/ID one cycle.
// Ports: *_ID decode inputs, flush_EX, stall_ext -> *_EX registered copies (valid_EX),
//        stall_IF/stall_ID, bubble_cnt/flush_cnt perf counters.
// Build option: PERF_CNT_EN enables the perf counters; otherwise they read 0.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int         XLEN            = 32,
    parameter logic [1:0] LOAD_RESULT_SEL = LOAD_RESULT_SEL_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ID,
    input  logic            reg_write_ID,
    input  logic            mem_write_ID,
    input  logic            uncond_jump_ID,
    input  logic            meet_branch_ID,
    input  logic            pc_jal_sel_ID,
    input  logic [1:0]      result_sel_ID,
    input  logic [1:0]      alu_sel_rs1_ID,
    input  logic [1:0]      alu_sel_rs2_ID,
    input  logic [3:0]      alu_ctrl_ID,
    input  logic [XLEN-1:0] rd1_ID,
    input  logic [XLEN-1:0] rd2_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic [XLEN-1:0] pc_plus4_ID,
    input  logic [XLEN-1:0] imm_ext_ID,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_ID,
    input  logic [2:0]      funct3_ID,
    input  logic            flush_EX,
    input  logic            stall_ext,
    output logic            valid_EX,
    output logic            reg_write_EX,
    output logic            mem_write_EX,
    output logic            uncond_jump_EX,
    output logic            meet_branch_EX,
    output logic            pc_jal_sel_EX,
    output logic [1:0]      result_sel_EX,
    output logic [1:0]      alu_sel_rs1_EX,
    output logic [1:0]      alu_sel_rs2_EX,
    output logic [3:0]      alu_ctrl_EX,
    output logic [XLEN-1:0] rd1_EX,
    output logic [XLEN-1:0] rd2_EX,
    output logic [XLEN-1:0] pc_EX,
    output logic [XLEN-1:0] pc_plus4_EX,
    output logic [XLEN-1:0] imm_ext_EX,
    output logic [4:0]      rs1_EX,
    output logic [4:0]      rs2_EX,
    output logic [4:0]      rd_EX,
    output logic [2:0]      funct3_EX,
    output logic            stall_IF,
    output logic            stall_ID,
    output logic [31:0]     bubble_cnt,
    output logic [31:0]     flush_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
    } data_t;

    ctrl_t ctrl_id, ctrl_q, ctrl_d;
    data_t data_id, data_q, data_d;
    logic  lu;
    logic  load_en;
    logic  bubble;

    assign ctrl_id = '{
        valid:       valid_ID,
        reg_write:   reg_write_ID,
        mem_write:   mem_write_ID,
        uncond_jump: uncond_jump_ID,
        meet_branch: meet_branch_ID,
        pc_jal_sel:  pc_jal_sel_ID,
        result_sel:  result_sel_ID,
        alu_sel_rs1: alu_sel_rs1_ID,
        alu_sel_rs2: alu_sel_rs2_ID,
        alu_ctrl:    alu_ctrl_ID
    };

    assign data_id = '{
        rd1:      rd1_ID,
        rd2:      rd2_ID,
        pc:       pc_ID,
        pc_plus4: pc_plus4_ID,
        imm_ext:  imm_ext_ID,
        rs1:      rs1_ID,
        rs2:      rs2_ID,
        rd:       rd_ID,
        funct3:   funct3_ID
    };

    id_ex_stage_load_use_detect #(
        .LOAD_RESULT_SEL (LOAD_RESULT_SEL)
    ) u_load_use_detect (
        .valid_ex_i      (ctrl_q.valid),
        .result_sel_ex_i (ctrl_q.result_sel),
        .rd_ex_i         (data_q.rd),
        .valid_id_i      (valid_ID),
        .rs1_id_i        (rs1_ID),
        .rs2_id_i        (rs2_ID),
        .lu_o            (lu)
    );

    // A flush squashes the load in EX, so any load-use it would cause is moot.
    assign stall_IF = (lu && !flush_EX) || stall_ext;
    assign stall_ID = stall_IF;

    // Flush beats the downstream hold: the squashed instruction must not survive.
    assign load_en = flush_EX || !stall_ext;
    assign bubble  = flush_EX || lu;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (load_en) begin
            ctrl_d = bubble ? make_bubble(ctrl_id) : ctrl_id;
            data_d = data_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign valid_EX       = ctrl_q.valid;
    assign reg_write_EX   = ctrl_q.reg_write;
    assign mem_write_EX   = ctrl_q.mem_write;
    assign uncond_jump_EX = ctrl_q.uncond_jump;
    assign meet_branch_EX = ctrl_q.meet_branch;
    assign pc_jal_sel_EX  = ctrl_q.pc_jal_sel;
    assign result_sel_EX  = ctrl_q.result_sel;
    assign alu_sel_rs1_EX = ctrl_q.alu_sel_rs1;
    assign alu_sel_rs2_EX = ctrl_q.alu_sel_rs2;
    assign alu_ctrl_EX    = ctrl_q.alu_ctrl;
    assign rd1_EX         = data_q.rd1;
    assign rd2_EX         = data_q.rd2;
    assign pc_EX          = data_q.pc;
    assign pc_plus4_EX    = data_q.pc_plus4;
    assign imm_ext_EX     = data_q.imm_ext;
    assign rs1_EX         = data_q.rs1;
    assign rs2_EX         = data_q.rs2;
    assign rd_EX          = data_q.rd;
    assign funct3_EX      = data_q.funct3;

`ifdef PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] flush_cnt_q;

    // bubble_cnt only counts load-use bubbles; a flush bubble or a held edge is not one.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (!flush_EX && !stall_ext && lu) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (flush_EX) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/wrap sequences, random run vs model.
// Latency: drives on negedge, checks stall #1 later and EX state #1 after posedge.
// Backpressure: flush_EX / stall_ext driven by the table and randomly.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        uncond_jump;
        logic        meet_branch;
        logic        pc_jal_sel;
        logic [1:0]  result_sel;
        logic [1:0]  alu_sel_rs1;
        logic [1:0]  alu_sel_rs2;
        logic [3:0]  alu_ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } stage_t;

    typedef struct {
        stage_t in;
        bit     fl;
        bit     se;
        bit     rs;
        bit     e_stall;
        bit     e_valid;
        bit     e_rw;
        bit     e_mw;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_EX = 1'b0;
    logic        stall_ext = 1'b0;
    stage_t      id = '0;
    stage_t      ex;
    logic        valid_EX, reg_write_EX, mem_write_EX, uncond_jump_EX, meet_branch_EX, pc_jal_sel_EX;
    logic [1:0]  result_sel_EX, alu_sel_rs1_EX, alu_sel_rs2_EX;
    logic [3:0]  alu_ctrl_EX;
    logic [31:0] rd1_EX, rd2_EX, pc_EX, pc_plus4_EX, imm_ext_EX;
    logic [4:0]  rs1_EX, rs2_EX, rd_EX;
    logic [2:0]  funct3_EX;
    logic        stall_IF, stall_ID;
    logic [31:0] bubble_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: what EX should hold, whether all of it is meaningful, and event counts.
    stage_t      m = '0;
    bit          m_full = 1'b1;
    logic [31:0] m_bcnt = '0;
    logic [31:0] m_fcnt = '0;
    bit          samp_stall;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .valid_ID       (id.valid),
        .reg_write_ID   (id.reg_write),
        .mem_write_ID   (id.mem_write),
        .uncond_jump_ID (id.uncond_jump),
        .meet_branch_ID (id.meet_branch),
        .pc_jal_sel_ID  (id.pc_jal_sel),
        .result_sel_ID  (id.result_sel),
        .alu_sel_rs1_ID (id.alu_sel_rs1),
        .alu_sel_rs2_ID (id.alu_sel_rs2),
        .alu_ctrl_ID    (id.alu_ctrl),
        .rd1_ID         (id.rd1),
        .rd2_ID         (id.rd2),
        .pc_ID          (id.pc),
        .pc_plus4_ID    (id.pc_plus4),
        .imm_ext_ID     (id.imm_ext),
        .rs1_ID         (id.rs1),
        .rs2_ID         (id.rs2),
        .rd_ID          (id.rd),
        .funct3_ID      (id.funct3),
        .flush_EX       (flush_EX),
        .stall_ext      (stall_ext),
        .valid_EX       (valid_EX),
        .reg_write_EX   (reg_write_EX),
        .mem_write_EX   (mem_write_EX),
        .uncond_jump_EX (uncond_jump_EX),
        .meet_branch_EX (meet_branch_EX),
        .pc_jal_sel_EX  (pc_jal_sel_EX),
        .result_sel_EX  (result_sel_EX),
        .alu_sel_rs1_EX (alu_sel_rs1_EX),
        .alu_sel_rs2_EX (alu_sel_rs2_EX),
        .alu_ctrl_EX    (alu_ctrl_EX),
        .rd1_EX         (rd1_EX),
        .rd2_EX         (rd2_EX),
        .pc_EX          (pc_EX),
        .pc_plus4_EX    (pc_plus4_EX),
        .imm_ext_EX     (imm_ext_EX),
        .rs1_EX         (rs1_EX),
        .rs2_EX         (rs2_EX),
        .rd_EX          (rd_EX),
        .funct3_EX      (funct3_EX),
        .stall_IF       (stall_IF),
        .stall_ID       (stall_ID),
        .bubble_cnt     (bubble_cnt),
        .flush_cnt      (flush_cnt)
    );

    assign ex = {valid_EX, reg_write_EX, mem_write_EX, uncond_jump_EX, meet_branch_EX, pc_jal_sel_EX,
                 result_sel_EX, alu_sel_rs1_EX, alu_sel_rs2_EX, alu_ctrl_EX,
                 rd1_EX, rd2_EX, pc_EX, pc_plus4_EX, imm_ext_EX, rs1_EX, rs2_EX, rd_EX, funct3_EX};

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stage_t rand_stage();
        stage_t s;
        s = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return s;
    endfunction

    function automatic stage_t mk(input bit v, input bit rw, input bit mw, input logic [1:0] rsel,
                                  input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        stage_t s;
        s             = rand_stage();
        s.valid       = v;
        s.reg_write   = rw;
        s.mem_write   = mw;
        s.uncond_jump = 1'b0;
        s.meet_branch = 1'b0;
        s.result_sel  = rsel;
        s.rs1         = rs1;
        s.rs2         = rs2;
        s.rd          = rd;
        return s;
    endfunction

    function automatic stage_t kill(input stage_t s);
        stage_t b;
        b = s;
        {b.valid, b.reg_write, b.mem_write, b.uncond_jump, b.meet_branch} = 5'b0;
        return b;
    endfunction

    // One clock: apply inputs, check the stall outputs, advance the model, check EX state.
    task automatic cycle(input stage_t in, input bit fl, input bit se, input bit rs);
        bit lu;
        bit exp_stall;
        @(negedge clk);
        id = in; flush_EX = fl; stall_ext = se; rst = rs;
        #1;
        // EX holds a load writing a nonzero register that the valid ID instruction names.
        lu = m.valid && (m.result_sel == 2'd1) && (m.rd != 5'd0) && in.valid &&
             ((m.rd == in.rs1) || (m.rd == in.rs2));
        exp_stall = (lu && !fl) || se;
        samp_stall = stall_IF;
        chk("stall_IF", stall_IF, exp_stall);
        chk("stall_ID", stall_ID, exp_stall);
        @(posedge clk);
        if (rs) begin
            m = '0; m_full = 1'b1; m_bcnt = '0; m_fcnt = '0;
        end else if (fl) begin
            m = kill(in); m_full = 1'b0; m_fcnt = m_fcnt + 32'd1;
        end else if (se) begin
            m = m;
        end else if (lu) begin
            m = kill(in); m_full = 1'b0; m_bcnt = m_bcnt + 32'd1;
        end else begin
            m = in; m_full = 1'b1;
        end
        #1;
        if (m_full) chk("ex_all", ex, m);
        else chk("ex_ctrl", {ex.valid, ex.reg_write, ex.mem_write, ex.uncond_jump, ex.meet_branch},
                 {m.valid, m.reg_write, m.mem_write, m.uncond_jump, m.meet_branch});
`ifdef PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, m_bcnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
`else
        chk("bubble_cnt_off", bubble_cnt, 32'd0);
        chk("flush_cnt_off", flush_cnt, 32'd0);
`endif
    endtask

    vec_t tbl[15];

    initial begin
        stage_t ld5, add5;
        ld5  = mk(1, 1, 0, 2'd1, 5'd1, 5'd2, 5'd5);
        add5 = mk(1, 1, 0, 2'd0, 5'd5, 5'd6, 5'd7);
        //           in                             fl se rs  stall vld rw mw
        tbl[0]  = '{ld5,                            0, 0, 0,  0,    1,  1, 0};
        tbl[1]  = '{add5,                           0, 0, 0,  1,    0,  0, 0};
        tbl[2]  = '{add5,                           0, 0, 0,  0,    1,  1, 0};
        tbl[3]  = '{mk(1, 1, 0, 2'd1, 3, 4, 0),     0, 0, 0,  0,    1,  1, 0};
        tbl[4]  = '{mk(1, 1, 0, 2'd0, 1, 0, 8),     0, 0, 0,  0,    1,  1, 0};
        tbl[5]  = '{mk(1, 0, 1, 2'd0, 2, 3, 0),     1, 0, 0,  0,    0,  0, 0};
        tbl[6]  = '{mk(1, 1, 0, 2'd1, 1, 2, 9),     0, 0, 0,  0,    1,  1, 0};
        tbl[7]  = '{mk(1, 1, 0, 2'd0, 9, 4, 3),     1, 0, 0,  0,    0,  0, 0};
        tbl[8]  = '{mk(1, 1, 0, 2'd0, 1, 2, 10),    0, 0, 0,  0,    1,  1, 0};
        tbl[9]  = '{mk(1, 0, 1, 2'd0, 3, 4, 11),    0, 1, 0,  1,    1,  1, 0};
        tbl[10] = '{mk(1, 1, 0, 2'd1, 10, 5, 1),    0, 1, 0,  1,    1,  1, 0};
        tbl[11] = '{mk(1, 1, 1, 2'd0, 6, 7, 2),     1, 1, 0,  1,    0,  0, 0};
        tbl[12] = '{mk(1, 1, 0, 2'd1, 1, 2, 12),    0, 0, 0,  0,    1,  1, 0};
        tbl[13] = '{mk(1, 1, 0, 2'd0, 3, 12, 13),   0, 0, 1,  1,    0,  0, 0};
        tbl[14] = '{tbl[13].in,                     0, 0, 0,  0,    1,  1, 0};

        // Reset held 3 cycles with busy ID inputs.
        for (int i = 0; i < 3; i++) cycle(mk(1, 1, 1, 2'd1, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b1);
        chk("rst_ex_zero", ex, 194'd0);
        chk("rst_bubble_cnt", bubble_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].in, tbl[i].fl, tbl[i].se, tbl[i].rs);
            chk($sformatf("vec%0d_stall", i), samp_stall, tbl[i].e_stall);
            chk($sformatf("vec%0d_ctrl", i), {valid_EX, reg_write_EX, mem_write_EX},
                {tbl[i].e_valid, tbl[i].e_rw, tbl[i].e_mw});
        end

`ifdef PERF_CNT_EN
        // Counter wrap: start at all-ones, one load-use bubble takes it to zero.
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        m_bcnt = 32'hFFFF_FFFF;
        cycle(ld5, 1'b0, 1'b0, 1'b0);
        cycle(add5, 1'b0, 1'b0, 1'b0);
        chk("bubble_wrap", bubble_cnt, 32'd0);
`endif

        // Random traffic with a small register pool so hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            stage_t s;
            s            = rand_stage();
            s.valid      = ($urandom_range(0, 3) != 0);
            s.result_sel = 2'($urandom_range(0, 3));
            s.rs1        = 5'($urandom_range(0, 3));
            s.rs2        = 5'($urandom_range(0, 3));
            s.rd         = 5'($urandom_range(0, 3));
            cycle(s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
